// File: rtl/uart_frame_io_wrapper_if.sv
// Bundles the UART byte-stream side and the compute-core frame side of
// uart_frame_io_wrapper. master = the wrapper, slave = the surrounding environment.
interface uart_frame_io_wrapper_if #(
  parameter int InputBytes  = 1,
  parameter int OutputBytes = 1
);
  logic [7:0]               rx_byte;
  logic                     rx_byte_valid;
  logic [7:0]               tx_byte;
  logic                     tx_byte_valid;
  logic                     tx_byte_ready;
  logic                     clear_to_send_out_n;
  logic [8*InputBytes-1:0]  flat_input;
  logic                     flat_input_valid;
  logic                     flat_input_ready;
  logic [8*OutputBytes-1:0] flat_output;
  logic                     flat_output_valid;
  logic                     flat_output_ready;
  logic                     frame_error;
  logic                     overrun_error;

  modport master (
    input  rx_byte, rx_byte_valid, tx_byte_ready, flat_input_ready,
           flat_output, flat_output_valid,
    output tx_byte, tx_byte_valid, clear_to_send_out_n, flat_input,
           flat_input_valid, flat_output_ready, frame_error, overrun_error
  );

  modport slave (
    output rx_byte, rx_byte_valid, tx_byte_ready, flat_input_ready,
           flat_output, flat_output_valid,
    input  tx_byte, tx_byte_valid, clear_to_send_out_n, flat_input,
           flat_input_valid, flat_output_ready, frame_error, overrun_error
  );
endinterface

// File: rtl/uart_frame_io_wrapper.sv
// Assembles multi-byte UART frames for a compute core and serialises its result
// back out LSB byte first, with inter-byte timeout resync and overrun reporting.
module uart_frame_io_wrapper #(
  parameter int InputBytes    = 1,
  parameter int OutputBytes   = 1,
  parameter int TimeoutClocks = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_frame_io_wrapper_if.master bus
);
  localparam int MaxBytes = (InputBytes > OutputBytes) ? InputBytes : OutputBytes;
  localparam int IdxW     = (MaxBytes > 1) ? $clog2(MaxBytes) : 1;
  localparam int TmrW     = (TimeoutClocks > 1) ? $clog2(TimeoutClocks) : 1;
  localparam logic [IdxW-1:0] LastIn  = IdxW'(InputBytes - 1);
  localparam logic [IdxW-1:0] LastOut = IdxW'(OutputBytes - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'((TimeoutClocks > 0) ? TimeoutClocks - 1 : 0);
  localparam logic [TmrW-1:0] TmrOne  = TmrW'(1);

  typedef enum logic [1:0] {ST_RX, ST_ISSUE, ST_WAIT, ST_TX} state_t;

  state_t                   state_reg, state_next;
  logic [IdxW-1:0]          byte_idx_reg, byte_idx_next;
  logic [TmrW-1:0]          timer_reg, timer_next;
  logic [8*InputBytes-1:0]  flat_input_reg, flat_input_next;
  logic                     flat_input_valid_reg, flat_input_valid_next;
  logic                     flat_output_ready_reg, flat_output_ready_next;
  logic [8*OutputBytes-1:0] tx_shift_reg, tx_shift_next;
  logic                     tx_valid_reg, tx_valid_next;
  logic                     cts_n_reg, cts_n_next;
  logic                     frame_error_reg, frame_error_next;
  logic                     overrun_error_reg, overrun_error_next;

  always_comb begin
    state_next             = state_reg;
    byte_idx_next          = byte_idx_reg;
    timer_next             = timer_reg;
    flat_input_next        = flat_input_reg;
    flat_input_valid_next  = flat_input_valid_reg;
    flat_output_ready_next = flat_output_ready_reg;
    tx_shift_next          = tx_shift_reg;
    tx_valid_next          = tx_valid_reg;
    frame_error_next       = 1'b0;
    overrun_error_next     = 1'b0;

    case (state_reg)
      ST_RX: begin
        if (bus.rx_byte_valid) begin
          // A strobe always wins over a simultaneous timeout expiry.
          flat_input_next[8*byte_idx_reg +: 8] = bus.rx_byte;
          timer_next = '0;
          if (byte_idx_reg == LastIn) begin
            byte_idx_next         = '0;
            flat_input_valid_next = 1'b1;
            state_next            = ST_ISSUE;
          end else begin
            byte_idx_next = byte_idx_reg + IdxOne;
          end
        end else if (TimeoutClocks > 0 && byte_idx_reg != '0) begin
          if (timer_reg == TmrLast) begin
            byte_idx_next    = '0;
            timer_next       = '0;
            frame_error_next = 1'b1;
          end else begin
            timer_next = timer_reg + TmrOne;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.flat_input_ready) begin
          flat_input_valid_next  = 1'b0;
          flat_output_ready_next = 1'b1;
          state_next             = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.flat_output_valid) begin
          tx_shift_next          = bus.flat_output;
          tx_valid_next          = 1'b1;
          flat_output_ready_next = 1'b0;
          state_next             = ST_TX;
        end
      end
      ST_TX: begin
        if (bus.tx_byte_ready) begin
          tx_shift_next = tx_shift_reg >> 8;
          if (byte_idx_reg == LastOut) begin
            byte_idx_next = '0;
            tx_valid_next = 1'b0;
            state_next    = ST_RX;
          end else begin
            byte_idx_next = byte_idx_reg + IdxOne;
          end
        end
      end
      default: state_next = ST_RX;
    endcase

    // Bytes arriving while the frame is in flight cannot be buffered.
    if (bus.rx_byte_valid && state_reg != ST_RX) begin
      overrun_error_next = 1'b1;
    end

    cts_n_next = (state_next != ST_RX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg             <= ST_RX;
      byte_idx_reg          <= '0;
      timer_reg             <= '0;
      flat_input_reg        <= '0;
      flat_input_valid_reg  <= 1'b0;
      flat_output_ready_reg <= 1'b0;
      tx_shift_reg          <= '0;
      tx_valid_reg          <= 1'b0;
      cts_n_reg             <= 1'b0;
      frame_error_reg       <= 1'b0;
      overrun_error_reg     <= 1'b0;
    end else begin
      state_reg             <= state_next;
      byte_idx_reg          <= byte_idx_next;
      timer_reg             <= timer_next;
      flat_input_reg        <= flat_input_next;
      flat_input_valid_reg  <= flat_input_valid_next;
      flat_output_ready_reg <= flat_output_ready_next;
      tx_shift_reg          <= tx_shift_next;
      tx_valid_reg          <= tx_valid_next;
      cts_n_reg             <= cts_n_next;
      frame_error_reg       <= frame_error_next;
      overrun_error_reg     <= overrun_error_next;
    end
  end

  assign bus.tx_byte             = tx_shift_reg[7:0];
  assign bus.tx_byte_valid       = tx_valid_reg;
  assign bus.clear_to_send_out_n = cts_n_reg;
  assign bus.flat_input          = flat_input_reg;
  assign bus.flat_input_valid    = flat_input_valid_reg;
  assign bus.flat_output_ready   = flat_output_ready_reg;
  assign bus.frame_error         = frame_error_reg;
  assign bus.overrun_error       = overrun_error_reg;
endmodule

// File: tb/tb_uart_frame_io_wrapper.sv
// Directed bench for uart_frame_io_wrapper: three instances cover 1/1-byte,
// 2/2-byte and 3-byte-with-timeout configurations; the bench plays the core.
`timescale 1ns/1ps
module tb_uart_frame_io_wrapper;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_frame_io_wrapper_if #(.InputBytes(1), .OutputBytes(1)) bus_a ();
  uart_frame_io_wrapper_if #(.InputBytes(2), .OutputBytes(2)) bus_b ();
  uart_frame_io_wrapper_if #(.InputBytes(3), .OutputBytes(1)) bus_c ();

  uart_frame_io_wrapper #(.InputBytes(1), .OutputBytes(1), .TimeoutClocks(0))
    dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  uart_frame_io_wrapper #(.InputBytes(2), .OutputBytes(2), .TimeoutClocks(0))
    dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
  uart_frame_io_wrapper #(.InputBytes(3), .OutputBytes(1), .TimeoutClocks(20))
    dut_c (.clk(clk), .rst(rst_c), .bus(bus_c));

  // Advance n edges, then settle 1ns so registered outputs are stable.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.rx_byte_valid = 1'b1; bus_b.rx_byte_valid = 1'b1;
    tick(2);
    bus_a.rx_byte_valid = 1'b0; bus_b.rx_byte_valid = 1'b0;
    n_checks++;
    if ({bus_a.tx_byte_valid, bus_a.clear_to_send_out_n, bus_a.flat_input_valid,
         bus_a.flat_output_ready, bus_a.frame_error, bus_a.overrun_error, bus_a.tx_byte,
         bus_a.flat_input} !== 22'h0) begin
      n_fail++; $display("FAIL reset_a: outputs not cleared");
    end
    n_checks++;
    if ({bus_b.tx_byte_valid, bus_b.clear_to_send_out_n, bus_b.flat_input_valid,
         bus_b.flat_output_ready, bus_b.frame_error, bus_b.overrun_error, bus_b.tx_byte,
         bus_b.flat_input} !== 30'h0) begin
      n_fail++; $display("FAIL reset_b: outputs not cleared");
    end
    n_checks++;
    if ({bus_c.tx_byte_valid, bus_c.clear_to_send_out_n, bus_c.flat_input_valid,
         bus_c.flat_output_ready, bus_c.frame_error, bus_c.overrun_error, bus_c.tx_byte,
         bus_c.flat_input} !== 38'h0) begin
      n_fail++; $display("FAIL reset_c: outputs not cleared");
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
  endtask

  // One complete 1-byte frame on instance A, core = add1.
  task automatic a_frame(input logic [7:0] b);
    logic [7:0] exp_out;
    exp_out = b + 8'd1;
    bus_a.rx_byte = b; bus_a.rx_byte_valid = 1'b1;
    tick();
    bus_a.rx_byte_valid = 1'b0;
    n_checks++;
    if ({bus_a.flat_input_valid, bus_a.clear_to_send_out_n, bus_a.flat_input} !== {2'b11, b}) begin
      n_fail++; $display("FAIL a_issue: got %h expected %h",
        {bus_a.flat_input_valid, bus_a.clear_to_send_out_n, bus_a.flat_input}, {2'b11, b});
    end
    bus_a.flat_input_ready = 1'b1;
    tick();
    bus_a.flat_input_ready = 1'b0;
    n_checks++;
    if ({bus_a.flat_input_valid, bus_a.flat_output_ready, bus_a.clear_to_send_out_n} !== 3'b011) begin
      n_fail++; $display("FAIL a_wait: got %b expected 011",
        {bus_a.flat_input_valid, bus_a.flat_output_ready, bus_a.clear_to_send_out_n});
    end
    bus_a.flat_output = exp_out; bus_a.flat_output_valid = 1'b1;
    tick();
    bus_a.flat_output_valid = 1'b0;
    n_checks++;
    if ({bus_a.tx_byte_valid, bus_a.clear_to_send_out_n, bus_a.flat_output_ready, bus_a.tx_byte}
        !== {3'b110, exp_out}) begin
      n_fail++; $display("FAIL a_tx: got %h expected %h",
        {bus_a.tx_byte_valid, bus_a.clear_to_send_out_n, bus_a.flat_output_ready, bus_a.tx_byte},
        {3'b110, exp_out});
    end
    bus_a.tx_byte_ready = 1'b1;
    tick();
    bus_a.tx_byte_ready = 1'b0;
    n_checks++;
    if ({bus_a.tx_byte_valid, bus_a.clear_to_send_out_n} !== 2'b00) begin
      n_fail++; $display("FAIL a_done: got %b expected 00",
        {bus_a.tx_byte_valid, bus_a.clear_to_send_out_n});
    end
    $display("a frame: in %h -> tx %h", b, exp_out);
  endtask

  // One complete 2-byte frame on instance B, core = swap halves.
  task automatic b_frame(input logic [7:0] b0, input logic [7:0] b1,
                         input int in_stall, input int tx_stall, input bit overrun);
    logic [15:0] exp_in;
    logic [15:0] exp_out;
    logic [7:0]  exp_byte;
    exp_in  = {b1, b0};
    exp_out = {exp_in[7:0], exp_in[15:8]};
    bus_b.rx_byte = b0; bus_b.rx_byte_valid = 1'b1;
    tick();
    n_checks++;
    if ({bus_b.flat_input_valid, bus_b.clear_to_send_out_n} !== 2'b00) begin
      n_fail++; $display("FAIL b_mid_frame: got %b expected 00",
        {bus_b.flat_input_valid, bus_b.clear_to_send_out_n});
    end
    bus_b.rx_byte = b1;
    tick();
    bus_b.rx_byte_valid = 1'b0;
    n_checks++;
    if ({bus_b.flat_input_valid, bus_b.clear_to_send_out_n, bus_b.flat_input} !== {2'b11, exp_in}) begin
      n_fail++; $display("FAIL b_issue: got %h expected %h",
        {bus_b.flat_input_valid, bus_b.clear_to_send_out_n, bus_b.flat_input}, {2'b11, exp_in});
    end
    for (int s = 0; s < in_stall; s++) begin
      tick();
      n_checks++;
      if ({bus_b.flat_input_valid, bus_b.flat_input} !== {1'b1, exp_in}) begin
        n_fail++; $display("FAIL b_issue_stall%0d: got %h expected %h", s,
          {bus_b.flat_input_valid, bus_b.flat_input}, {1'b1, exp_in});
      end
    end
    bus_b.flat_input_ready = 1'b1;
    tick();
    bus_b.flat_input_ready = 1'b0;
    n_checks++;
    if ({bus_b.flat_input_valid, bus_b.flat_output_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b_wait: got %b expected 01",
        {bus_b.flat_input_valid, bus_b.flat_output_ready});
    end
    if (overrun) begin
      bus_b.rx_byte = 8'hEE; bus_b.rx_byte_valid = 1'b1;
      tick();
      bus_b.rx_byte_valid = 1'b0;
      n_checks++;
      if ({bus_b.overrun_error, bus_b.flat_output_ready, bus_b.clear_to_send_out_n, bus_b.flat_input}
          !== {3'b111, exp_in}) begin
        n_fail++; $display("FAIL b_overrun: got %h expected %h",
          {bus_b.overrun_error, bus_b.flat_output_ready, bus_b.clear_to_send_out_n, bus_b.flat_input},
          {3'b111, exp_in});
      end
      tick();
      n_checks++;
      if (bus_b.overrun_error !== 1'b0) begin
        n_fail++; $display("FAIL b_overrun_pulse: got %b expected 0", bus_b.overrun_error);
      end
    end
    bus_b.flat_output = exp_out; bus_b.flat_output_valid = 1'b1;
    tick();
    bus_b.flat_output_valid = 1'b0;
    bus_b.flat_output = 16'h0;
    for (int k = 0; k < 2; k++) begin
      exp_byte = exp_out[8*k +: 8];
      n_checks++;
      if ({bus_b.tx_byte_valid, bus_b.tx_byte} !== {1'b1, exp_byte}) begin
        n_fail++; $display("FAIL b_tx%0d: got %h expected %h", k,
          {bus_b.tx_byte_valid, bus_b.tx_byte}, {1'b1, exp_byte});
      end
      for (int s = 0; s < tx_stall; s++) begin
        tick();
        n_checks++;
        if ({bus_b.tx_byte_valid, bus_b.tx_byte} !== {1'b1, exp_byte}) begin
          n_fail++; $display("FAIL b_tx%0d_stall%0d: got %h expected %h", k, s,
            {bus_b.tx_byte_valid, bus_b.tx_byte}, {1'b1, exp_byte});
        end
      end
      bus_b.tx_byte_ready = 1'b1;
      tick();
      bus_b.tx_byte_ready = 1'b0;
    end
    n_checks++;
    if ({bus_b.tx_byte_valid, bus_b.clear_to_send_out_n} !== 2'b00) begin
      n_fail++; $display("FAIL b_done: got %b expected 00",
        {bus_b.tx_byte_valid, bus_b.clear_to_send_out_n});
    end
    $display("b frame: in %h -> out %h (stall %0d/%0d overrun %0d)",
             exp_in, exp_out, in_stall, tx_stall, overrun);
  endtask

  task automatic test_single_byte();
    a_frame(8'h55);
  endtask

  task automatic test_back_to_back();
    a_frame(8'h10);
    a_frame(8'hFF);
  endtask

  task automatic test_two_byte();
    b_frame(8'h34, 8'h12, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    b_frame(8'hCD, 8'hAB, 5, 3, 1'b0);
  endtask

  task automatic test_overrun();
    b_frame(8'h5A, 8'hC3, 0, 0, 1'b1);
  endtask

  task automatic test_reset_in_tx();
    bus_b.rx_byte = 8'h02; bus_b.rx_byte_valid = 1'b1;
    tick();
    bus_b.rx_byte = 8'h01;
    tick();
    bus_b.rx_byte_valid = 1'b0;
    bus_b.flat_input_ready = 1'b1;
    tick();
    bus_b.flat_input_ready = 1'b0;
    bus_b.flat_output = 16'hBBAA; bus_b.flat_output_valid = 1'b1;
    tick();
    bus_b.flat_output_valid = 1'b0;
    bus_b.tx_byte_ready = 1'b1;
    tick();
    bus_b.tx_byte_ready = 1'b0;
    n_checks++;
    if ({bus_b.tx_byte_valid, bus_b.tx_byte} !== 9'h1BB) begin
      n_fail++; $display("FAIL rst_tx_second: got %h expected 1bb", {bus_b.tx_byte_valid, bus_b.tx_byte});
    end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    n_checks++;
    if ({bus_b.tx_byte_valid, bus_b.clear_to_send_out_n, bus_b.tx_byte, bus_b.flat_input} !== 26'h0) begin
      n_fail++; $display("FAIL rst_tx_abort: got %h expected 0",
        {bus_b.tx_byte_valid, bus_b.clear_to_send_out_n, bus_b.tx_byte, bus_b.flat_input});
    end
    $display("b frame: reset during tx after first byte");
    b_frame(8'h78, 8'h56, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    bus_c.rx_byte = 8'hAA; bus_c.rx_byte_valid = 1'b1;
    tick();
    bus_c.rx_byte_valid = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (bus_c.frame_error === 1'b1) pulses++;
      n_checks++;
      if (bus_c.frame_error !== (k == 20)) begin
        n_fail++; $display("FAIL timeout_idle%0d: got %b expected %b", k, bus_c.frame_error, (k == 20));
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL timeout_pulses: got %0d expected 1", pulses);
    end
    bus_c.rx_byte_valid = 1'b1;
    bus_c.rx_byte = 8'h01; tick();
    bus_c.rx_byte = 8'h02; tick();
    bus_c.rx_byte = 8'h03; tick();
    bus_c.rx_byte_valid = 1'b0;
    n_checks++;
    if ({bus_c.flat_input_valid, bus_c.flat_input} !== 25'h1030201) begin
      n_fail++; $display("FAIL timeout_resync: got %h expected 1030201", {bus_c.flat_input_valid, bus_c.flat_input});
    end
    $display("c frame: timeout discard then in %h", bus_c.flat_input);
    rst_c = 1'b1; tick(); rst_c = 1'b0;
  endtask

  // Strobe landing on the expiry cycle must be kept with no error.
  task automatic test_timeout_boundary();
    int errs;
    errs = 0;
    bus_c.rx_byte = 8'h11; bus_c.rx_byte_valid = 1'b1;
    tick();
    bus_c.rx_byte_valid = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (bus_c.frame_error !== 1'b0) errs++;
    end
    bus_c.rx_byte = 8'h22; bus_c.rx_byte_valid = 1'b1;
    tick();
    if (bus_c.frame_error !== 1'b0) errs++;
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL boundary_no_error: got %0d error cycles expected 0", errs);
    end
    bus_c.rx_byte = 8'h33;
    tick();
    bus_c.rx_byte_valid = 1'b0;
    n_checks++;
    if ({bus_c.flat_input_valid, bus_c.flat_input} !== 25'h1332211) begin
      n_fail++; $display("FAIL boundary_frame: got %h expected 1332211", {bus_c.flat_input_valid, bus_c.flat_input});
    end
    $display("c frame: strobe on expiry cycle, in %h", bus_c.flat_input);
  endtask

  initial begin
    bus_a.rx_byte = 8'h0; bus_a.rx_byte_valid = 1'b0; bus_a.tx_byte_ready = 1'b0;
    bus_a.flat_input_ready = 1'b0; bus_a.flat_output = 8'h0; bus_a.flat_output_valid = 1'b0;
    bus_b.rx_byte = 8'h0; bus_b.rx_byte_valid = 1'b0; bus_b.tx_byte_ready = 1'b0;
    bus_b.flat_input_ready = 1'b0; bus_b.flat_output = 16'h0; bus_b.flat_output_valid = 1'b0;
    bus_c.rx_byte = 8'h0; bus_c.rx_byte_valid = 1'b0; bus_c.tx_byte_ready = 1'b0;
    bus_c.flat_input_ready = 1'b0; bus_c.flat_output = 8'h0; bus_c.flat_output_valid = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_two_byte();
    test_backpressure();
    test_overrun();
    test_reset_in_tx();
    test_timeout();
    test_timeout_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
